// File: rtl/dmem_be_if.sv
// Request/response bundle for the byte-addressable data memory: MEM-stage request,
// pipelined response and sticky error capture.
interface dmem_be_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        err_sticky;
    logic [31:0] err_addr;
    logic        err_clr;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, err_clr,
        input  resp_valid, resp_rdata, resp_err, err_sticky, err_addr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, err_clr,
        output resp_valid, resp_rdata, resp_err, err_sticky, err_addr
    );
endinterface

// File: rtl/dmem_be.sv
// Byte-addressable single-port data memory with byte/half/word access, sign/zero
// extension, READ_LAT-deep response pipeline and sticky first-error capture.
module dmem_be #(
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    dmem_be_if.slave bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [31:0] RAM [DEPTH];

    logic [AW-1:0] word_idx;
    logic          err_range;
    logic          err_align;
    logic          req_err;
    logic          wr_en;
    logic [3:0]    lane_en;
    logic [31:0]   wr_data;

    assign word_idx  = bus.req_addr[AW+1:2];
    assign err_range = (bus.req_addr[31:2] >= DEPTH_W);
    assign req_err   = err_range | err_align;
    assign wr_en     = bus.req_valid & bus.req_we & ~req_err;

    always_comb begin
        err_align = 1'b0;
        case (bus.req_size)
            2'b00:   err_align = 1'b0;
            2'b01:   err_align = bus.req_addr[0];
            2'b10:   err_align = (bus.req_addr[1:0] != 2'b00);
            default: err_align = 1'b1;
        endcase
    end

    // Right-aligned store data is replicated across lanes so each lane's
    // write enable alone picks the correct byte.
    always_comb begin
        wr_data = bus.req_wdata;
        case (bus.req_size)
            2'b00:   wr_data = {4{bus.req_wdata[7:0]}};
            2'b01:   wr_data = {2{bus.req_wdata[15:0]}};
            default: wr_data = bus.req_wdata;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_en
        assign lane_en[gi] = (bus.req_size == 2'b00) ? (bus.req_addr[1:0] == 2'(gi)) :
                             (bus.req_size == 2'b01) ? (bus.req_addr[1] == (gi >= 2)) :
                                                       1'b1;
    end

    // Storage array: byte-lane writes plus registered read, no reset.
    logic [31:0] rd_word_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    RAM[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        rd_word_reg <= RAM[word_idx];
    end

    // First pipeline stage: request attributes aligned with the registered read word.
    logic       s0_valid_reg;
    logic       s0_err_reg;
    logic       s0_load_reg;
    logic [1:0] s0_size_reg;
    logic       s0_unsigned_reg;
    logic [1:0] s0_lane_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid_reg    <= 1'b0;
            s0_err_reg      <= 1'b0;
            s0_load_reg     <= 1'b0;
            s0_size_reg     <= 2'b00;
            s0_unsigned_reg <= 1'b0;
            s0_lane_reg     <= 2'b00;
        end else begin
            s0_valid_reg    <= bus.req_valid;
            s0_err_reg      <= bus.req_valid & req_err;
            s0_load_reg     <= bus.req_valid & ~bus.req_we & ~req_err;
            s0_size_reg     <= bus.req_size;
            s0_unsigned_reg <= bus.req_unsigned;
            s0_lane_reg     <= bus.req_addr[1:0];
        end
    end

    logic [7:0]  lane_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;
    logic [31:0] s0_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_byte
        assign lane_byte[gi] = rd_word_reg[8*gi +: 8];
    end

    always_comb begin
        sel_byte = lane_byte[s0_lane_reg];
        sel_half = s0_lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
        ext_data = rd_word_reg;
        case (s0_size_reg)
            2'b00:   ext_data = {{24{~s0_unsigned_reg & sel_byte[7]}}, sel_byte};
            2'b01:   ext_data = {{16{~s0_unsigned_reg & sel_half[15]}}, sel_half};
            default: ext_data = rd_word_reg;
        endcase
        s0_data = s0_load_reg ? ext_data : 32'h0;
    end

    logic        out_valid;
    logic        out_err;
    logic [31:0] out_data;

    if (READ_LAT == 1) begin : g_lat1
        assign out_valid = s0_valid_reg;
        assign out_err   = s0_err_reg;
        assign out_data  = s0_data;
    end else begin : g_latn
        // Extended data travels through the remaining READ_LAT-1 stages.
        logic        v_reg [READ_LAT-1];
        logic        e_reg [READ_LAT-1];
        logic [31:0] d_reg [READ_LAT-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < READ_LAT - 1; k++) begin
                    v_reg[k] <= 1'b0;
                    e_reg[k] <= 1'b0;
                    d_reg[k] <= 32'h0;
                end
            end else begin
                v_reg[0] <= s0_valid_reg;
                e_reg[0] <= s0_err_reg;
                d_reg[0] <= s0_data;
                for (int k = 1; k < READ_LAT - 1; k++) begin
                    v_reg[k] <= v_reg[k-1];
                    e_reg[k] <= e_reg[k-1];
                    d_reg[k] <= d_reg[k-1];
                end
            end
        end

        assign out_valid = v_reg[READ_LAT-2];
        assign out_err   = e_reg[READ_LAT-2];
        assign out_data  = d_reg[READ_LAT-2];
    end

    assign bus.resp_valid = out_valid;
    assign bus.resp_err   = out_valid & out_err;
    assign bus.resp_rdata = out_valid ? out_data : 32'h0;

    // Sticky error: a new error in the same cycle as err_clr wins over the clear.
    logic        err_sticky_reg;
    logic [31:0] err_addr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky_reg <= 1'b0;
            err_addr_reg   <= 32'h0;
        end else if (bus.req_valid && req_err) begin
            err_sticky_reg <= 1'b1;
            if (!err_sticky_reg || bus.err_clr) begin
                err_addr_reg <= bus.req_addr;
            end
        end else if (bus.err_clr) begin
            err_sticky_reg <= 1'b0;
            err_addr_reg   <= 32'h0;
        end
    end

    assign bus.err_sticky = err_sticky_reg;
    assign bus.err_addr   = err_addr_reg;

endmodule

// File: doc/dmem_be.md
# dmem_be

Parametrised, byte-addressable data memory for the pipelined core, the successor to the fixed word-only `dmem`. Accepts one load or store request per cycle from the MEM stage and supports byte, halfword and word access with sign/zero extension. Read data is delivered through a configurable-latency pipeline, and every request is checked for misalignment and out-of-range addresses with a sticky error capture. Storage is a single-port word array named `RAM`, so benches can keep peeking `dmem_be_u.RAM[i]`.

## Interface
- `DEPTH`, 64: number of 32-bit words in `RAM`; power of two, 4..65536.
- `READ_LAT`, 1: cycles from request acceptance to `resp_valid`; 1..4.
- `clk` input 1: single clock, all state on the rising edge.
- `reset` input 1: asynchronous, active-high; clears pipeline and error state, not `RAM` contents.
- `req_valid` input 1: request present this cycle; always accepted (no backpressure).
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: response for the request accepted `READ_LAT` cycles earlier.
- `resp_rdata` output 32: extended load data; 0 for stores and errored requests.
- `resp_err` output 1: the responding request was errored.
- `err_sticky` output 1: set by any errored request; held until `err_clr` or `reset`.
- `err_addr` output 32: `req_addr` of the first errored request since the last clear.
- `err_clr` input 1: synchronous clear of `err_sticky` and `err_addr`.

## Operation
- Word index = `req_addr[31:2]`; byte lane = `req_addr[1:0]`; little-endian (lane 0 = bits [7:0]).
- Error conditions:
  - index ≥ `DEPTH`;
  - `req_size`=11;
  - halfword with `req_addr[0]`=1;
  - word with `req_addr[1:0]`≠00.
- Any error condition makes the request errored.
- Store, no error: at the accepting edge, write only the addressed lanes (byte: 1 lane; half: lanes 0-1 or 2-3; word: all 4). Other lanes are unchanged.
- Errored store: no `RAM` write at all.
- Load, no error: read the word at the accepting edge. Select the lane(s), then sign- or zero-extend to 32 bits. Word loads ignore `req_unsigned`.
- Errored load: returns `resp_rdata`=0.
- Response pipeline:
  - A `READ_LAT`-deep shift register carries valid, err, and data (or the lane/size/sign info).
  - A response is produced for every accepted request, loads and stores alike.
  - A store responds with `resp_rdata`=0 and `resp_err` as computed.
- Error capture:
  - On an errored request, `err_sticky`←1.
  - `err_addr` is loaded only if `err_sticky` was 0.
  - If `err_clr` and a new errored request coincide, the new error wins: sticky=1 and `err_addr` = the new address.
- `RAM` is uninitialised. Benches preload it through the hierarchy or `$readmemh`.

## Timing
- Reset values:
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `err_sticky`=0, `err_addr`=0;
  - all pipeline stages invalid.
- Reset asserted mid-operation discards in-flight responses immediately (outputs drop asynchronously). A store already written stays written.
- Latency: a request accepted at edge N gives `resp_valid`=1 in the cycle after edge N+`READ_LAT`-1. With `READ_LAT`=1, the response is visible in the cycle after the accepting edge.
- Throughput: 1 request/cycle; back-to-back responses are contiguous.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. A single port makes same-cycle overlap impossible.
- A request with `req_valid`=0 produces no response and no side effect, regardless of the other inputs.

## Test plan
- Preload `RAM[1]`=0x11223344. Word store 0x99 to addr 0x4, then word load 0x4 → `RAM[1]`=0x00000099 and `resp_rdata`=0x00000099 after `READ_LAT` cycles.
- `RAM[2]`=0x80FF7F01.
  - Byte loads from 0x8..0xB with `req_unsigned`=0 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Halfword load 0xA with `req_unsigned`=1 → 0x000080FF.
- `RAM[3]`=0. Byte store 0xAB to 0xD, then halfword store 0xBEEF to 0xE → `RAM[3]`=0xBEEFAB00.
- Word store to 0x6 (misaligned) → `RAM` unchanged, `resp_err`=1, `err_sticky`=1, `err_addr`=0x6.
  - Then a load from 4*`DEPTH` → `resp_err`=1, `resp_rdata`=0, `err_addr` still 0x6.
  - `err_clr` → sticky=0.
- `READ_LAT`=3: issue 5 back-to-back loads, deassert `reset`... then assert `reset` after the third accept → `resp_valid` drops immediately and stays 0 after release.
- Sweep `DEPTH`=4,1024 with `READ_LAT`=1,4: address 4*`DEPTH`-4 is accepted, 4*`DEPTH` errors; response latency equals `READ_LAT` exactly.
